// File: rtl/gray_to_binary_monitor_if.sv
// Signal bundle between the switch/host side (master) and the Gray-to-binary monitor (slave).
interface gray_to_binary_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] gray;
  logic             err_clr;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] leds;
  logic             valid;
  logic             step_err;
  logic [CNT_W-1:0] change_count;

  modport master (
    output gray, err_clr,
    input  binary, leds, valid, step_err, change_count
  );

  modport slave (
    input  gray, err_clr,
    output binary, leds, valid, step_err, change_count
  );
endinterface

// File: rtl/gray_to_binary_monitor.sv
// Synchronises a Gray-coded switch word, optionally debounces it, and reports the binary value.
// Define GRAY_DEBOUNCE_EN to insert the STABLE_CYCLES stability filter ahead of acceptance.
module gray_to_binary_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gray_to_binary_monitor_if.slave  bus
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] acc_gray;
  logic [WIDTH-1:0] binary_q;
  logic             valid_q;
  logic             step_err_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.gray;
      s2 <= s1;
    end
  end

`ifdef GRAY_DEBOUNCE_EN
  localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(STABLE_CYCLES);

  logic [WIDTH-1:0]    cand;
  logic [CNT_BITS-1:0] cnt;

  // cnt saturates at STABLE_CYCLES so a settled word is accepted exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign accept = (s2 == cand) && (cnt == CNT_LAST) && (cand != acc_gray);
`else
  assign accept = (s2 != acc_gray);
`endif

  // x & (x-1) is nonzero exactly when more than one bit of x is set
  assign diff      = s2 ^ acc_gray;
  assign multi_bit = |(diff & (diff - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_gray   <= '0;
      binary_q   <= '0;
      valid_q    <= 1'b0;
      step_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        acc_gray <= s2;
        binary_q <= gray2bin(s2);
        count_q  <= count_q + 1'b1;
      end
      if (accept && multi_bit) begin
        step_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        step_err_q <= 1'b0;
      end
    end
  end

  assign bus.binary       = binary_q;
  assign bus.leds         = ~binary_q;
  assign bus.valid        = valid_q;
  assign bus.step_err     = step_err_q;
  assign bus.change_count = count_q;

endmodule

// File: tb/tb_gray_to_binary_monitor.sv
// Directed self-checking bench for gray_to_binary_monitor (WIDTH=4, STABLE_CYCLES=4, CNT_W=8).
module tb_gray_to_binary_monitor;

`ifdef GRAY_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   valid_pulses;
  int   pulses_before;

  gray_to_binary_monitor_if #(.WIDTH(4), .CNT_W(8)) bus ();

  gray_to_binary_monitor #(
    .WIDTH(4),
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts valid pulses sampled mid-cycle, away from the rising edge
  always @(negedge clk) begin
    if (rst_n && bus.valid) valid_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g, input int hold);
    bus.gray = g;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    bus.gray    = 4'b0000;
    bus.err_clr = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    valid_pulses = 0;
    rst_n        = 1'b0;
    bus.gray     = 4'b1111;
    bus.err_clr  = 1'b0;

    // Reset values with a nonzero input present
    #2;
    checkOutput("rst_binary", bus.binary, 4'b0000);
    checkOutput("rst_leds", bus.leds, 4'b1111);
    checkOutput("rst_valid", bus.valid, 1'b0);
    checkOutput("rst_count", bus.change_count, 8'd0);
    checkOutput("rst_step_err", bus.step_err, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    checkOutput("release_early_binary", bus.binary, 4'b0000);
    checkOutput("release_no_valid", valid_pulses, 0);
    @(posedge clk);
    #1;
    checkOutput("release_binary", bus.binary, 4'b1010);
    checkOutput("release_valid", bus.valid, 1'b1);
    checkOutput("release_count", bus.change_count, 8'd1);

    // Two-bit step 0000 -> 0110
    doReset();
    pulses_before = valid_pulses;
    applyStimulus(4'b0110, LAT);
    checkOutput("step2_valid", bus.valid, 1'b1);
    checkOutput("step2_binary", bus.binary, 4'b0100);
    checkOutput("step2_leds", bus.leds, 4'b1011);
    checkOutput("step2_count", bus.change_count, 8'd1);
    checkOutput("step2_step_err", bus.step_err, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("step2_valid_low", bus.valid, 1'b0);
    checkOutput("step2_pulses", valid_pulses - pulses_before, 1);

    // err_clr alone, then err_clr coinciding with a setting acceptance
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    checkOutput("errclr_alone", bus.step_err, 1'b0);
    applyStimulus(4'b0101, LAT - 1);
    checkOutput("errclr_pre_binary", bus.binary, 4'b0100);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("errclr_set_wins", bus.step_err, 1'b1);
    checkOutput("errclr_binary", bus.binary, 4'b0110);
    @(posedge clk);
    #1;
    checkOutput("errclr_next", bus.step_err, 1'b0);
    bus.err_clr = 1'b0;

    // Single-bit sequence 0001, 0011, 0010
    doReset();
    pulses_before = valid_pulses;
    applyStimulus(4'b0001, 10);
    checkOutput("seq_b1", bus.binary, 4'b0001);
    applyStimulus(4'b0011, 10);
    checkOutput("seq_b2", bus.binary, 4'b0010);
    applyStimulus(4'b0010, 10);
    checkOutput("seq_b3", bus.binary, 4'b0011);
    checkOutput("seq_pulses", valid_pulses - pulses_before, 3);
    checkOutput("seq_step_err", bus.step_err, 1'b0);
    checkOutput("seq_count", bus.change_count, 8'd3);

    // Holding the accepted word produces nothing further
    pulses_before = valid_pulses;
    applyStimulus(4'b0010, 10);
    checkOutput("same_word_pulses", valid_pulses - pulses_before, 0);
    checkOutput("same_word_count", bus.change_count, 8'd3);

`ifdef GRAY_DEBOUNCE_EN
    // Short glitch rejected, then a stable change accepted after 7 edges
    pulses_before = valid_pulses;
    applyStimulus(4'b0110, 3);
    applyStimulus(4'b0010, 10);
    checkOutput("glitch_binary", bus.binary, 4'b0011);
    checkOutput("glitch_pulses", valid_pulses - pulses_before, 0);
    applyStimulus(4'b0110, 6);
    checkOutput("debounce_early", bus.binary, 4'b0011);
    @(posedge clk);
    #1;
    checkOutput("debounce_accept", bus.binary, 4'b0100);
`endif

    // Asynchronous reset takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_binary", bus.binary, 4'b0000);
    checkOutput("async_leds", bus.leds, 4'b1111);
    checkOutput("async_count", bus.change_count, 8'd0);

    // Reset while a new word is in the pipeline restarts the full latency
    rst_n    = 1'b1;
    bus.gray = 4'b0000;
    @(posedge clk);
    #1;
    applyStimulus(4'b0111, 2);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    checkOutput("midreset_early", bus.binary, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("midreset_binary", bus.binary, 4'b0101);

    // 256 single-bit changes wrap the change counter
    doReset();
    pulses_before = valid_pulses;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(((i % 2) == 0) ? 4'b0001 : 4'b0000, LAT + 2);
      if (i == 254) checkOutput("wrap_255", bus.change_count, 8'd255);
    end
    checkOutput("wrap_count", bus.change_count, 8'd0);
    checkOutput("wrap_pulses", valid_pulses - pulses_before, 256);
    checkOutput("wrap_binary", bus.binary, 4'b0000);
    checkOutput("wrap_step_err", bus.step_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
